// File: rtl/score_counter.sv
// Packed-BCD game score with a serial one-digit-per-cycle adder and a
// frame-coherent shadow copy (disp_digits) that the renderer reads.
module score_counter #(
    parameter int NUM_DIGITS = 5,
    parameter int ADD_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    clear,
    input  logic                    add_valid,
    input  logic [4*ADD_DIGITS-1:0] add_pts,
    output logic                    add_ready,
    output logic                    busy,
    output logic                    saturated,
    output logic [4*NUM_DIGITS-1:0] disp_digits
);

    localparam int SW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [SW-1:0]    ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic [SW-1:0]    score_r, score_nxt_s;
    logic [SW-1:0]    addend_r, addend_nxt_s;
    logic             sat_r, sat_nxt_s;
    logic [SW-1:0]    disp_r, disp_nxt_s;
    logic             pending_r, pending_nxt_s;

    logic [SW-1:0]    pts_ext_s;
    logic [SW-1:0]    addend_in_s;
    logic [3:0]       cur_digit_s;
    logic [3:0]       add_digit_s;
    logic [4:0]       sum_s;
    logic [4:0]       sum_adj_s;
    logic [3:0]       digit_s;
    logic             carry_out_s;

    // Out-of-range input nibbles are treated as 9 rather than rejected.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
        logic [3:0] res;
        if (nib > 4'd9) begin
            res = 4'd9;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    assign pts_ext_s = SW'(add_pts);

    // Widen the addend to full score width (upper digits zero) and clamp each nibble.
    always_comb begin
        addend_in_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            addend_in_s[i*4 +: 4] = clamp_bcd(pts_ext_s[i*4 +: 4]);
        end
    end

    // Single-digit BCD add for the digit selected by idx_r.
    always_comb begin
        cur_digit_s = score_r[{idx_r, 2'b00} +: 4];
        add_digit_s = addend_r[{idx_r, 2'b00} +: 4];
        sum_s       = {1'b0, cur_digit_s} + {1'b0, add_digit_s} + {4'b0000, carry_r};
        sum_adj_s   = sum_s - 5'd10;
        if (sum_s > 5'd9) begin
            digit_s     = sum_adj_s[3:0];
            carry_out_s = 1'b1;
        end else begin
            digit_s     = sum_s[3:0];
            carry_out_s = 1'b0;
        end
    end

    // Next-state, datapath and publish logic.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        carry_nxt_s   = carry_r;
        score_nxt_s   = score_r;
        addend_nxt_s  = addend_r;
        sat_nxt_s     = sat_r;
        disp_nxt_s    = disp_r;
        pending_nxt_s = pending_r;

        if (clear) begin
            state_nxt_s = IDLE;
            idx_nxt_s   = '0;
            carry_nxt_s = 1'b0;
            score_nxt_s = '0;
            sat_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (add_valid) begin
                        addend_nxt_s = addend_in_s;
                        state_nxt_s  = ADD;
                        idx_nxt_s    = '0;
                        carry_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ADD: begin
                    score_nxt_s[{idx_r, 2'b00} +: 4] = digit_s;
                    carry_nxt_s = carry_out_s;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = '0;
                        // A carry out of the top digit clamps instead of wrapping.
                        if (carry_out_s) begin
                            score_nxt_s = ALL_NINES;
                            sat_nxt_s   = 1'b1;
                        end else begin
                            sat_nxt_s   = sat_r;
                        end
                    end else begin
                        idx_nxt_s = idx_r + IDX_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    idx_nxt_s   = '0;
                    carry_nxt_s = 1'b0;
                end
            endcase
        end

        // The shadow copy only ever sees a settled score.
        if ((state_r == IDLE) && !clear) begin
            if (frame_start || pending_r) begin
                disp_nxt_s    = score_r;
                pending_nxt_s = 1'b0;
            end else begin
                pending_nxt_s = pending_r;
            end
        end else begin
            if (frame_start) begin
                pending_nxt_s = 1'b1;
            end else begin
                pending_nxt_s = pending_r;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            score_r   <= '0;
            addend_r  <= '0;
            sat_r     <= 1'b0;
            disp_r    <= '0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            carry_r   <= carry_nxt_s;
            score_r   <= score_nxt_s;
            addend_r  <= addend_nxt_s;
            sat_r     <= sat_nxt_s;
            disp_r    <= disp_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    assign add_ready   = (state_r == IDLE) & ~clear & rst_n;
    assign busy        = (state_r == ADD);
    assign saturated   = sat_r;
    assign disp_digits = disp_r;

endmodule
